// File: rtl/ff_conv_bank.sv
// Multi-mode flip-flop bank: per-cycle D / T / JK / SR next-state selection plus
// up/down counting built from chained T stages. SR conflicts hold and are flagged.
module ff_conv_bank #(
   parameter int                 WIDTH     = 8,
   parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}},
   parameter int                 ERR_CNT_W = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [2:0]           mode,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic [WIDTH-1:0]     q,
   output logic [WIDTH-1:0]     qn,
   output logic                 sr_err,
   output logic [ERR_CNT_W-1:0] err_cnt,
   output logic                 wrap,
   output logic                 illegal_mode
);

   localparam logic [2:0] MODE_D  = 3'd0;
   localparam logic [2:0] MODE_T  = 3'd1;
   localparam logic [2:0] MODE_JK = 3'd2;
   localparam logic [2:0] MODE_SR = 3'd3;
   localparam logic [2:0] MODE_UP = 3'd4;
   localparam logic [2:0] MODE_DN = 3'd5;

   logic [WIDTH-1:0]     q_q, q_d;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic                 sr_err_q, sr_err_d;
   logic                 wrap_q, wrap_d;
   logic                 illegal_q, illegal_d;
   logic [WIDTH-1:0]     t_up_s, t_dn_s;
   logic [WIDTH-1:0]     sr_set_s, sr_clr_s;

   // Ripple toggle enables: stage i toggles when all lower bits are 1 (up) or 0 (down).
   always_comb begin
      t_up_s    = {WIDTH{1'b0}};
      t_dn_s    = {WIDTH{1'b0}};
      t_up_s[0] = 1'b1;
      t_dn_s[0] = 1'b1;
      for (int i = 1; i < WIDTH; i++) begin
         t_up_s[i] = t_up_s[i-1] & q_q[i-1];
         t_dn_s[i] = t_dn_s[i-1] & ~q_q[i-1];
      end
   end

   assign sr_set_s = a & ~b;
   assign sr_clr_s = ~a & b;

   // Next-state selection for the bank and its status flags.
   always_comb begin
      q_d       = q_q;
      err_cnt_d = err_cnt_q;
      sr_err_d  = 1'b0;
      wrap_d    = 1'b0;
      illegal_d = 1'b0;
      if (en) begin
         case (mode)
            MODE_D:  q_d = a;
            MODE_T:  q_d = q_q ^ a;
            MODE_JK: q_d = (a & ~q_q) | (~b & q_q);
            MODE_SR: begin
               // a=b=1 falls out of this form as hold, so no bit ever goes unknown
               q_d      = (q_q & ~sr_clr_s) | sr_set_s;
               sr_err_d = |(a & b);
               if (sr_err_d && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
                  err_cnt_d = err_cnt_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
               end else begin
                  err_cnt_d = err_cnt_q;
               end
            end
            MODE_UP: begin
               q_d    = q_q ^ t_up_s;
               wrap_d = &q_q;
            end
            MODE_DN: begin
               q_d    = q_q ^ t_dn_s;
               wrap_d = ~|q_q;
            end
            default: illegal_d = 1'b1;
         endcase
      end else begin
         q_d = q_q;
      end
   end

   // State and flag registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_q       <= RESET_VAL;
         err_cnt_q <= {ERR_CNT_W{1'b0}};
         sr_err_q  <= 1'b0;
         wrap_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         q_q       <= q_d;
         err_cnt_q <= err_cnt_d;
         sr_err_q  <= sr_err_d;
         wrap_q    <= wrap_d;
         illegal_q <= illegal_d;
      end
   end

   assign q            = q_q;
   assign qn           = ~q_q;
   assign sr_err       = sr_err_q;
   assign err_cnt      = err_cnt_q;
   assign wrap         = wrap_q;
   assign illegal_mode = illegal_q;

endmodule

// File: tb/tb_ff_conv_bank.sv
// Scoreboard bench for ff_conv_bank (WIDTH=4, RESET_VAL=5): directed scenarios then
// randomized traffic, checked against an arithmetic reference model.
module tb_ff_conv_bank;

   logic       clk = 1'b0;
   logic       rst, en;
   logic [2:0] mode;
   logic [3:0] a, b;
   logic [3:0] q, qn, err_cnt;
   logic       sr_err, wrap, illegal_mode;

   ff_conv_bank #(.WIDTH(4), .RESET_VAL(4'h5), .ERR_CNT_W(4)) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b),
      .q(q), .qn(qn), .sr_err(sr_err), .err_cnt(err_cnt),
      .wrap(wrap), .illegal_mode(illegal_mode)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] q;
      logic       sr;
      logic [3:0] cnt;
      logic       wr;
      logic       ill;
   } exp_t;

   exp_t sb[$];
   int   vectors     = 0;
   int   miscompares = 0;

   // reference state
   int   m_q   = 5;
   int   m_cnt = 0;

   task automatic apply(input logic r, input logic e, input logic [2:0] m,
                        input logic [3:0] av, input logic [3:0] bv);
      exp_t x;
      int   nq;
      @(negedge clk);
      rst = r; en = e; mode = m; a = av; b = bv;
      x.sr = 1'b0; x.wr = 1'b0; x.ill = 1'b0;
      nq = m_q;
      if (r) begin
         nq = 5; m_cnt = 0;
      end else if (e) begin
         case (m)
            3'd0: nq = av;
            3'd1: nq = m_q ^ av;
            3'd2, 3'd3: begin
               nq = 0;
               for (int i = 0; i < 4; i++) begin
                  int cur;
                  cur = (m_q >> i) & 1;
                  case ({av[i], bv[i]})
                     2'b00: cur = cur;
                     2'b01: cur = 0;
                     2'b10: cur = 1;
                     default: cur = (m == 3'd2) ? 1 - cur : cur;
                  endcase
                  nq = nq | (cur << i);
               end
               if (m == 3'd3 && (av & bv) != 4'd0) begin
                  x.sr = 1'b1;
                  if (m_cnt < 15) m_cnt = m_cnt + 1;
               end
            end
            3'd4: begin x.wr = (m_q == 15); nq = (m_q + 1) % 16; end
            3'd5: begin x.wr = (m_q == 0);  nq = (m_q + 15) % 16; end
            default: x.ill = 1'b1;
         endcase
      end
      m_q   = nq;
      x.q   = 4'(m_q);
      x.cnt = 4'(m_cnt);
      sb.push_back(x);
   endtask

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Monitor: one output vector per clock, compared against the oldest expectation.
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            x = sb.pop_front();
            vectors++;
            chk("q",            q,                  x.q);
            chk("qn",           qn,                 ~x.q);
            chk("err_cnt",      err_cnt,            x.cnt);
            chk("sr_err",       {3'b000, sr_err},   {3'b000, x.sr});
            chk("wrap",         {3'b000, wrap},     {3'b000, x.wr});
            chk("illegal_mode", {3'b000, illegal_mode}, {3'b000, x.ill});
         end
      end
   end

   initial begin
      int w;
      rst = 1'b1; en = 1'b0; mode = 3'd0; a = 4'h0; b = 4'h0;
      // reset in COUNT_UP, then count once
      apply(1'b1, 1'b1, 3'd4, 4'h0, 4'h0);
      apply(1'b0, 1'b1, 3'd4, 4'h0, 4'h0);
      // D then T, then disabled
      apply(1'b0, 1'b1, 3'd0, 4'hC, 4'h0);
      apply(1'b0, 1'b1, 3'd1, 4'h6, 4'h0);
      apply(1'b0, 1'b1, 3'd1, 4'h6, 4'h0);
      apply(1'b0, 1'b0, 3'd1, 4'hF, 4'h0);
      // JK
      apply(1'b0, 1'b1, 3'd0, 4'h0, 4'h0);
      apply(1'b0, 1'b1, 3'd2, 4'b1100, 4'b1010);
      apply(1'b0, 1'b1, 3'd2, 4'b1100, 4'b1010);
      // SR conflict and saturation
      apply(1'b0, 1'b1, 3'd0, 4'h3, 4'h0);
      apply(1'b0, 1'b1, 3'd3, 4'b0101, 4'b0110);
      apply(1'b0, 1'b1, 3'd0, 4'h3, 4'h0);
      for (int i = 0; i < 20; i++) apply(1'b0, 1'b1, 3'd3, 4'hF, 4'hF);
      // counter wrap both ways
      apply(1'b0, 1'b1, 3'd0, 4'hE, 4'h0);
      for (int i = 0; i < 3; i++) apply(1'b0, 1'b1, 3'd4, 4'h0, 4'h0);
      for (int i = 0; i < 2; i++) apply(1'b0, 1'b1, 3'd5, 4'h0, 4'h0);
      // illegal mode, then reset mid-count at 9
      apply(1'b0, 1'b1, 3'd7, 4'hA, 4'h5);
      apply(1'b0, 1'b1, 3'd6, 4'h3, 4'h3);
      apply(1'b0, 1'b1, 3'd0, 4'h8, 4'h0);
      apply(1'b0, 1'b1, 3'd4, 4'h0, 4'h0);
      apply(1'b1, 1'b1, 3'd4, 4'h0, 4'h0);
      apply(1'b0, 1'b1, 3'd4, 4'h0, 4'h0);
      // randomized traffic
      for (int i = 0; i < 500; i++) begin
         apply(($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
               ($urandom_range(0, 99) < 80) ? 1'b1 : 1'b0,
               3'($urandom_range(0, 7)),
               4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)));
      end
      w = 0;
      while (sb.size() > 0 && w < 10) begin
         @(posedge clk);
         w++;
      end
      #2;
      if (sb.size() > 0) begin
         miscompares++;
         $display("FAIL drain: %0d expectations left, expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
